// File: rtl/fib_ser_pkg.sv
// Shared constants, types and helpers for the Fibonacci pair serializer.
package fib_ser_pkg;

    localparam int unsigned FIB_SER_W_DEFAULT     = 16;
    localparam int unsigned FIB_SER_DEPTH_DEFAULT = 8;

    typedef logic [15:0] term_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fib_ser_mem.sv
// DEPTH x W term storage: two writes per cycle (wr_ptr, wr_ptr+1), combinational read at rd_ptr.
module fib_ser_mem
    import fib_ser_pkg::*;
#(
    parameter int unsigned W     = FIB_SER_W_DEFAULT,
    parameter int unsigned DEPTH = FIB_SER_DEPTH_DEFAULT,
    localparam int unsigned PW   = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] wr_ptr,
    input  logic [W-1:0]  wdata0,
    input  logic [W-1:0]  wdata1,
    input  logic [PW-1:0] rd_ptr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_p1;

    // The second word wraps on its own, so a pair may straddle the end of the array.
    assign wr_ptr_p1 = wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_ptr]    <= wdata0;
            mem_q[wr_ptr_p1] <= wdata1;
        end
    end

    assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/fib_pair_serializer.sv
// Accepts {num, num2} pairs and re-emits them one term per cycle through a circular FIFO.
// Optional recurrence checker on the output stream is compiled in with FIB_CHECK_EN.
module fib_pair_serializer
    import fib_ser_pkg::*;
#(
    parameter int unsigned W     = FIB_SER_W_DEFAULT,
    parameter int unsigned DEPTH = FIB_SER_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_num,
    input  logic [W-1:0] in_num2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         err
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // Flags depend on registered count only, so out_ready never reaches in_ready.
    assign in_ready  = (DEPTH_C - count_q) >= CW'(2);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(2);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(2);
            2'b01:   count_d = count_q - CW'(1);
            2'b11:   count_d = count_q + CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fib_ser_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .wr_ptr (wr_ptr_q),
        .wdata0 (in_num),
        .wdata1 (in_num2),
        .rd_ptr (rd_ptr_q),
        .rdata  (out_data)
    );

`ifdef FIB_CHECK_EN
    logic [W-1:0] p1_q, p1_d;
    logic [W-1:0] p2_q, p2_d;
    logic [1:0]   seen_q, seen_d;
    logic         err_q, err_d;
    logic [W-1:0] fib_sum;

    assign fib_sum = p1_q + p2_q;

    // The check arms only once two earlier terms have been observed.
    always_comb begin
        p1_d   = p1_q;
        p2_d   = p2_q;
        seen_d = seen_q;
        err_d  = err_q;
        if (pop) begin
            p1_d = out_data;
            p2_d = p1_q;
            if (seen_q != 2'd2) seen_d = seen_q + 2'd1;
            if (seen_q == 2'd2 && out_data != fib_sum) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_q   <= '0;
            p2_q   <= '0;
            seen_q <= '0;
            err_q  <= 1'b0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Scoreboard bench for fib_pair_serializer: expected terms queued on push, compared on pop.
module tb_fib_pair_serializer;

    localparam int W = 16;
`ifdef FIB_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_num = '0;
    logic [W-1:0] in_num2 = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         err;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] exp_q[$];
    logic         did_push;
    logic         did_pop;
    logic [W-1:0] pop_data;
    logic [W-1:0] exp_v;

    always #5 clk = ~clk;

    fib_pair_serializer #(.W(W), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_num2   (in_num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    // Called at a falling edge: drives one cycle of stimulus and records what fired at the next rising edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy);
        in_valid  = v;
        in_num    = a;
        in_num2   = b;
        out_ready = rdy;
        #1;
        did_push = in_valid && in_ready;
        did_pop  = out_valid && out_ready;
        pop_data = out_data;
        if (did_pop) $display("pop  data=%0d", pop_data);
        if (did_push) begin
            exp_q.push_back(a);
            exp_q.push_back(b);
            $display("push pair=(%0d,%0d)", a, b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL post_reset_flags: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_basic_order();
        step(1'b1, 16'd1, 16'd1, 1'b1);
        n_checks++;
        if (did_pop !== 1'b0) $display("FAIL basic_first_cycle_pop: got %b expected 0", did_pop);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd1)
            $display("FAIL basic_latency: got valid=%b data=%0d expected valid=1 data=1", out_valid, out_data);
        else n_pass++;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            if (k == 0)      step(1'b1, 16'd2, 16'd3, 1'b1);
            else if (k == 1) step(1'b1, 16'd5, 16'd8, 1'b1);
            else             step(1'b0, 16'd0, 16'd0, 1'b1);
            if (did_pop) begin
                n_checks++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (pop_data !== exp_v) $display("FAIL basic_order: got %0d expected %0d", pop_data, exp_v);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL basic_drained: got pending=%0d valid=%b expected pending=0 valid=0", exp_q.size(), out_valid);
        else n_pass++;
    endtask

    task automatic test_fill_backpressure();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, W'(10 + 2 * k), W'(11 + 2 * k), 1'b0);
            n_checks++;
            if (did_push !== 1'b1) $display("FAIL fill_push%0d: got %b expected 1", k, did_push);
            else n_pass++;
        end
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'd99, 16'd98, 1'b0);
            n_checks++;
            if (did_push !== 1'b0 || out_data !== 16'd10)
                $display("FAIL fill_hold: got push=%b data=%0d expected push=0 data=10", did_push, out_data);
            else n_pass++;
        end
    endtask

    task automatic test_drain_with_push();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) step(1'b1, 16'd20, 16'd21, 1'b1);
            else        step(1'b0, 16'd0, 16'd0, 1'b1);
            n_checks++;
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if (did_pop !== 1'b1 || pop_data !== exp_v)
                $display("FAIL drain_pop%0d: got pop=%b data=%0d expected pop=1 data=%0d", k, did_pop, pop_data, exp_v);
            else n_pass++;
            n_checks++;
            if (in_ready !== (k == 1)) $display("FAIL drain_in_ready%0d: got %b expected %b", k, in_ready, (k == 1));
            else n_pass++;
        end
        n_checks++;
        if (did_push !== 1'b1) $display("FAIL drain_simul_push: got %b expected 1", did_push);
        else n_pass++;
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1);
            if (did_pop) begin
                n_checks++;
                exp_v = exp_q.pop_front();
                if (pop_data !== exp_v) $display("FAIL drain_order: got %0d expected %0d", pop_data, exp_v);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL drain_empty: got pending=%0d valid=%b expected pending=0 valid=0", exp_q.size(), out_valid);
        else n_pass++;
    endtask

    task automatic test_wrap_stream();
        logic [W-1:0] fib [1:40];
        logic [W-1:0] a, b;
        int pair_idx = 0;
        int n_pop = 0;
        fib[1] = 16'd1;
        fib[2] = 16'd1;
        for (int i = 3; i <= 40; i++) fib[i] = fib[i-1] + fib[i-2];
        for (int cyc = 0; cyc < 600 && n_pop < 40; cyc++) begin
            if (pair_idx < 20) begin
                a = fib[2 * pair_idx + 1];
                b = fib[2 * pair_idx + 2];
            end else begin
                a = '0;
                b = '0;
            end
            step(pair_idx < 20, a, b, $urandom_range(0, 3) != 0);
            if (did_push) pair_idx++;
            if (did_pop) begin
                n_pop++;
                n_checks++;
                if (pop_data !== fib[n_pop]) $display("FAIL wrap_term%0d: got %0d expected %0d", n_pop, pop_data, fib[n_pop]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        n_checks++;
        if (n_pop != 40 || exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL wrap_complete: got pops=%0d pending=%0d valid=%b expected pops=40 pending=0 valid=0",
                     n_pop, exp_q.size(), out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'd30, 16'd31, 1'b0);
        step(1'b1, 16'd32, 16'd33, 1'b0);
        step(1'b1, 16'd34, 16'd35, 1'b0);
        step(1'b0, 16'd0, 16'd0, 1'b1);
        n_checks++;
        if (pop_data !== 16'd30) $display("FAIL rstmid_pre_pop: got %0d expected 30", pop_data);
        else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_async: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        else n_pass++;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_release_valid: got %b expected 0", out_valid);
        else n_pass++;
        step(1'b1, 16'd13, 16'd21, 1'b1);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1);
            if (did_pop) begin
                n_checks++;
                exp_v = exp_q.pop_front();
                if (pop_data !== exp_v) $display("FAIL rstmid_order: got %0d expected %0d", pop_data, exp_v);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rstmid_drained: got pending=%0d valid=%b expected pending=0 valid=0", exp_q.size(), out_valid);
        else n_pass++;
    endtask

    task automatic test_err();
        logic exp_err = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step(1'b1, 16'd1, 16'd1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            if (k == 0) step(1'b1, 16'd2, 16'd4, 1'b1);
            else        step(1'b0, 16'd0, 16'd0, 1'b1);
            if (did_pop) begin
                n_checks++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (pop_data !== exp_v) $display("FAIL err_order: got %0d expected %0d", pop_data, exp_v);
                else n_pass++;
                if (pop_data == 16'd4) exp_err = CHK_EN;
            end
            n_checks++;
            if (err !== exp_err) $display("FAIL err_flag%0d: got %b expected %b", k, err, exp_err);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_basic_order();
        test_fill_backpressure();
        test_drain_with_push();
        test_wrap_stream();
        test_reset_mid();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
